// File: rtl/mac_acc_pipe.sv
// Pipelined signed multiply-accumulate over framed operand streams.
// One shifted, saturated result is produced per frame.
module mac_acc_pipe #(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 0,
  parameter int MAX_LEN = 64
) (
  input  logic                             clk,
  input  logic                             sclr_n,
  input  logic                             ce,
  input  logic                             in_valid,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic signed [DATA_W-1:0]         a,
  input  logic signed [COEF_W-1:0]         b,
  output logic                             out_valid,
  output logic signed [OUT_W-1:0]          p,
  output logic [$clog2(MAX_LEN+1)-1:0]     out_len,
  output logic                             sat,
  output logic                             err
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(MAX_LEN + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN =
    {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic                     v1;
  logic                     first1;
  logic                     last1;

  logic [0:0]               state;
  logic [0:0]               state_n;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_n;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_n;
  logic                     frame_sat;
  logic                     fsat_n;
  logic                     fin;
  logic                     err_n;

  logic signed [ACC_W-1:0]  prod_x;
  logic signed [ACC_W:0]    sum_w;
  logic                     acc_ovf;
  logic signed [ACC_W-1:0]  sum_sat;
  logic signed [ACC_W-1:0]  shifted;
  logic [ACC_W-OUT_W:0]     top_bits;
  logic                     out_ovf;
  logic signed [OUT_W-1:0]  p_n;

  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      prod   <= '0;
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else if (ce) begin
      prod   <= a * b;
      v1     <= in_valid;
      first1 <= in_first;
      last1  <= in_last;
    end
  end

  assign prod_x  = ACC_W'(prod);
  assign sum_w   = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_x);
  assign acc_ovf = sum_w[ACC_W] != sum_w[ACC_W-1];

  always_comb begin
    sum_sat = sum_w[ACC_W-1:0];
    if (acc_ovf) begin
      sum_sat = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    fsat_n  = frame_sat;
    fin     = 1'b0;
    err_n   = 1'b0;
    if (v1) begin
      unique case (1'b1)
        first1: begin
          err_n   = (state == ACCUM);
          acc_n   = prod_x;
          cnt_n   = CNT_W'(1);
          fsat_n  = 1'b0;
          state_n = ACCUM;
        end
        (!first1 && state == ACCUM): begin
          acc_n  = sum_sat;
          cnt_n  = cnt + CNT_W'(1);
          fsat_n = frame_sat | acc_ovf;
        end
        (!first1 && state == IDLE): begin
          err_n = 1'b1;
        end
        default: ;
      endcase
      // a frame hitting MAX_LEN without last is closed and flagged
      if (state_n == ACCUM &&
          (last1 || cnt_n == CNT_W'(MAX_LEN))) begin
        fin     = 1'b1;
        err_n   = err_n | !last1;
        state_n = IDLE;
      end
    end
  end

  assign shifted  = acc_n >>> SHIFT;
  assign top_bits = shifted[ACC_W-1:OUT_W-1];
  assign out_ovf  = !((&top_bits) || !(|top_bits));

  always_comb begin
    p_n = shifted[OUT_W-1:0];
    if (out_ovf) begin
      p_n = shifted[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      frame_sat <= 1'b0;
      out_valid <= 1'b0;
      p         <= '0;
      out_len   <= '0;
      sat       <= 1'b0;
      err       <= 1'b0;
    end else if (ce) begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      frame_sat <= fsat_n;
      out_valid <= fin;
      err       <= err_n;
      if (fin) begin
        p       <= p_n;
        out_len <= cnt_n;
        sat     <= fsat_n | out_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Testbench for mac_acc_pipe: two instances (default, SHIFT=2/MAX_LEN=4)
// driven with the same stream and checked against a frame-level model.
module tb_mac_acc_pipe;

  logic clk = 1'b0;
  logic sclr_n = 1'b0;
  logic ce = 1'b0;
  logic in_valid = 1'b0;
  logic in_first = 1'b0;
  logic in_last = 1'b0;
  logic signed [7:0] a = '0;
  logic signed [7:0] b = '0;

  logic ov0, sat0, err0, ov1, sat1, err1;
  logic signed [15:0] p0, p1;
  logic [6:0] len0;
  logic [2:0] len1;
  logic [25:0] obs [2];

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mac_acc_pipe u0 (
    .clk(clk), .sclr_n(sclr_n), .ce(ce),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .a(a), .b(b),
    .out_valid(ov0), .p(p0), .out_len(len0), .sat(sat0), .err(err0)
  );

  mac_acc_pipe #(.SHIFT(2), .MAX_LEN(4)) u1 (
    .clk(clk), .sclr_n(sclr_n), .ce(ce),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .a(a), .b(b),
    .out_valid(ov1), .p(p1), .out_len(len1), .sat(sat1), .err(err1)
  );

  assign obs[0] = {ov0, p0, len0, sat0, err0};
  assign obs[1] = {ov1, p1, {4'b0, len1}, sat1, err1};

  // reference model: frame arithmetic per instance
  int SH [2] = '{0, 2};
  int ML [2] = '{64, 4};
  localparam longint AMAX = 64'sd8388607;
  localparam longint AMIN = -64'sd8388608;

  bit     mf [2];
  longint msum [2];
  int     mcnt [2];
  bit     mfs [2];
  bit     pf [2], pe [2], ps [2];
  logic [15:0] pp [2];
  logic [6:0]  pl [2];
  bit     ev_ov [2], ev_err [2], ev_sat [2];
  logic [15:0] ev_p [2];
  logic [6:0]  ev_len [2];

  function automatic logic [25:0] expv(int i);
    return {ev_ov[i], ev_p[i], ev_len[i], ev_sat[i], ev_err[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mf[i] = 0; msum[i] = 0; mcnt[i] = 0; mfs[i] = 0;
      pf[i] = 0; pe[i] = 0; ps[i] = 0; pp[i] = '0; pl[i] = '0;
      ev_ov[i] = 0; ev_err[i] = 0; ev_sat[i] = 0;
      ev_p[i] = '0; ev_len[i] = '0;
    end
  endtask

  task automatic model_beat(int i);
    longint pr, s;
    bit cl;
    pf[i] = 0;
    pe[i] = 0;
    if (!in_valid) return;
    pr = longint'(a) * longint'(b);
    if (in_first) begin
      pe[i] = mf[i];
      mf[i] = 1; msum[i] = pr; mcnt[i] = 1; mfs[i] = 0;
    end else if (!mf[i]) begin
      pe[i] = 1;
      return;
    end else begin
      msum[i] = msum[i] + pr;
      mcnt[i] = mcnt[i] + 1;
      if (msum[i] > AMAX) begin msum[i] = AMAX; mfs[i] = 1; end
      if (msum[i] < AMIN) begin msum[i] = AMIN; mfs[i] = 1; end
    end
    if (in_last || mcnt[i] == ML[i]) begin
      pf[i] = 1;
      if (!in_last) pe[i] = 1;
      s = msum[i] >>> SH[i];
      cl = 0;
      if (s > 32767) begin s = 32767; cl = 1; end
      if (s < -32768) begin s = -32768; cl = 1; end
      pp[i] = s[15:0];
      pl[i] = 7'(mcnt[i]);
      ps[i] = mfs[i] | cl;
      mf[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      ev_ov[i] = pf[i];
      ev_err[i] = pe[i];
      if (pf[i]) begin
        ev_p[i] = pp[i]; ev_len[i] = pl[i]; ev_sat[i] = ps[i];
      end
      model_beat(i);
    end
  endtask

  task automatic drive(bit v, bit f, bit l, int av, int bv, bit c);
    in_valid = v; in_first = f; in_last = l;
    a = 8'(av); b = 8'(bv); ce = c;
    @(posedge clk);
    if (sclr_n && ce) model_edge();
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, $urandom, $urandom, 1);
  endtask

  task automatic test_reset();
    sclr_n = 0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, 1);
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs[i] !== 26'd0) begin
          nfail++;
          $display("FAIL reset dut%0d got=%h exp=0", i, obs[i]);
        end
      end
    end
    sclr_n = 1;
    idle();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs[i] !== expv(i) || obs[i] !== 26'd0) begin
        nfail++;
        $display("FAIL reset_idle dut%0d got=%h exp=%h", i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_frame3();
    drive(1, 1, 0, 3, 4, 1);
    drive(1, 0, 0, -2, 5, 1);
    drive(1, 0, 1, 127, 127, 1);
    nchk++;
    if (ov0 !== 1'b0) begin
      nfail++;
      $display("FAIL frame3_early got ov=%b exp ov=0", ov0);
    end
    idle();
    nchk++;
    if (ov0 !== 1 || p0 !== 16'sd16131 || len0 !== 7'd3 || sat0 !== 0) begin
      nfail++;
      $display("FAIL frame3 got ov=%b p=%0d len=%0d sat=%b exp 1 16131 3 0",
               ov0, p0, len0, sat0);
    end
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs[i] !== expv(i)) begin
        nfail++;
        $display("FAIL frame3_model dut%0d got=%h exp=%h", i, obs[i], expv(i));
      end
    end
    idle();
  endtask

  task automatic test_single();
    drive(1, 1, 1, -128, -128, 1);
    drive(1, 1, 1, 0, -7, 1);
    nchk++;
    if (ov0 !== 1 || p0 !== 16'sd16384 || len0 !== 7'd1) begin
      nfail++;
      $display("FAIL single got ov=%b p=%0d len=%0d exp 1 16384 1",
               ov0, p0, len0);
    end
    idle();
    nchk++;
    if (ov0 !== 1 || p0 !== 16'sd0 || len0 !== 7'd1) begin
      nfail++;
      $display("FAIL single_b2b got ov=%b p=%0d len=%0d exp 1 0 1",
               ov0, p0, len0);
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs[i] !== expv(i)) begin
        nfail++;
        $display("FAIL single_hold dut%0d got=%h exp=%h", i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_saturation();
    drive(1, 1, 0, 127, 127, 1);
    drive(1, 0, 0, 127, 127, 1);
    drive(1, 0, 1, 127, 127, 1);
    idle();
    nchk++;
    if (ov0 !== 1 || p0 !== 16'sd32767 || sat0 !== 1) begin
      nfail++;
      $display("FAIL sat_out got ov=%b p=%0d sat=%b exp 1 32767 1",
               ov0, p0, sat0);
    end
    nchk++;
    if (ov1 !== 1 || p1 !== 16'sd12096 || sat1 !== 0) begin
      nfail++;
      $display("FAIL sat_shift2 got ov=%b p=%0d sat=%b exp 1 12096 0",
               ov1, p1, sat1);
    end
    idle();
  endtask

  task automatic test_errors();
    drive(1, 0, 0, 5, 5, 1);
    idle();
    nchk++;
    if (err0 !== 1 || ov0 !== 0) begin
      nfail++;
      $display("FAIL err_idle got err=%b ov=%b exp 1 0", err0, ov0);
    end
    idle();
    nchk++;
    if (err0 !== 0) begin
      nfail++;
      $display("FAIL err_pulse got err=%b exp 0", err0);
    end
    // restart mid-frame
    drive(1, 1, 0, 1, 1, 1);
    drive(1, 0, 0, 2, 2, 1);
    drive(1, 1, 0, 3, 3, 1);
    drive(1, 0, 1, 4, 4, 1);
    nchk++;
    if (err0 !== 1 || ov0 !== 0) begin
      nfail++;
      $display("FAIL err_restart got err=%b ov=%b exp 1 0", err0, ov0);
    end
    idle();
    nchk++;
    if (ov0 !== 1 || p0 !== 16'sd25 || len0 !== 7'd2 || err0 !== 0) begin
      nfail++;
      $display("FAIL restart_frame got ov=%b p=%0d len=%0d err=%b exp 1 25 2 0",
               ov0, p0, len0, err0);
    end
    // forced close on the MAX_LEN=4 instance
    for (int k = 0; k < 5; k++) drive(1, k == 0, 0, 1, 1, 1);
    nchk++;
    if (ov1 !== 1 || len1 !== 3'd4 || err1 !== 1 || ov0 !== 0) begin
      nfail++;
      $display("FAIL forced got ov1=%b len1=%0d err1=%b ov0=%b exp 1 4 1 0",
               ov1, len1, err1, ov0);
    end
    drive(1, 0, 1, 1, 1, 1);
    idle();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs[i] !== expv(i)) begin
        nfail++;
        $display("FAIL forced_model dut%0d got=%h exp=%h", i, obs[i], expv(i));
      end
    end
    nchk++;
    if (ov0 !== 1 || len0 !== 7'd6 || p0 !== 16'sd6) begin
      nfail++;
      $display("FAIL long_frame got ov=%b len=%0d p=%0d exp 1 6 6",
               ov0, len0, p0);
    end
    idle();
  endtask

  task automatic test_stall();
    int nres;
    nres = 0;
    drive(1, 1, 0, 10, 10, 1);
    for (int k = 0; k < 3; k++)
      drive(1, 1, 1, $urandom, $urandom, 0);
    drive(1, 0, 0, -3, 7, 1);
    drive(1, 0, 1, 2, 50, 1);
    for (int k = 0; k < 3; k++)
      drive(0, 0, 0, 0, 0, 0);
    idle();
    if (ov0) nres++;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, $urandom, $urandom, 0);
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs[i] !== expv(i)) begin
          nfail++;
          $display("FAIL stall_hold dut%0d got=%h exp=%h", i, obs[i], expv(i));
        end
      end
    end
    nchk++;
    if (ov0 !== 1 || p0 !== 16'sd179 || len0 !== 7'd3) begin
      nfail++;
      $display("FAIL stall_sum got ov=%b p=%0d len=%0d exp 1 179 3",
               ov0, p0, len0);
    end
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      idle();
      if (ov0) nres++;
    end
    nchk++;
    if (nres !== 1) begin
      nfail++;
      $display("FAIL stall_results got=%0d exp=1", nres);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 0, 20, 20, 1);
    drive(1, 0, 0, 20, 20, 1);
    drive(1, 0, 0, 20, 20, 1);
    in_valid = 0;
    sclr_n = 0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs[i] !== 26'd0) begin
        nfail++;
        $display("FAIL reset_mid dut%0d got=%h exp=0", i, obs[i]);
      end
    end
    drive(1, 0, 1, 20, 20, 1);
    sclr_n = 1;
    for (int k = 0; k < 3; k++) begin
      idle();
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs[i] !== expv(i) || obs[i][25] !== 1'b0) begin
          nfail++;
          $display("FAIL reset_mid_after dut%0d got=%h exp=%h",
                   i, obs[i], expv(i));
        end
      end
    end
  endtask

  task automatic test_random();
    int av, bv;
    for (int k = 0; k < 600; k++) begin
      av = ($urandom % 8 == 0) ? 0 : int'($urandom);
      bv = ($urandom % 8 == 0) ? 0 : int'($urandom);
      drive($urandom % 4 != 0, $urandom % 5 == 0, $urandom % 4 == 0,
            av, bv, $urandom % 6 != 0);
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs[i] !== expv(i)) begin
          nfail++;
          $display("FAIL random%0d dut%0d got=%h exp=%h",
                   k, i, obs[i], expv(i));
        end
      end
    end
    for (int k = 0; k < 3; k++) idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame3();
    test_single();
    test_saturation();
    test_errors();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mac_acc_pipe.md
Name: mac_acc_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate. Successor to the single-product MAC cell.
- Accepts a framed stream of (a, b) operand pairs delimited by first/last flags and sums their products in a wide accumulator.
- Emits one shifted, saturated result per frame.
- Sits between the operand/weight fetch logic and the activation stage in the conv datapath; one instance per output channel.

Parameters:
- DATA_W, 8, signed width of operand a
- COEF_W, 8, signed width of operand b
- ACC_W, 24, signed accumulator width; must be >= DATA_W+COEF_W
- OUT_W, 16, signed output width; must be <= ACC_W
- SHIFT, 0, arithmetic right shift applied to the accumulator before output saturation
- MAX_LEN, 64, maximum terms per frame

Ports:
- clk  in  1  rising-edge clock
- sclr_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all registers advance only when ce=1
- in_valid  in  1  operand pair valid this cycle
- in_first  in  1  first term of frame (qualified by in_valid)
- in_last  in  1  last term of frame (qualified by in_valid)
- a  in  DATA_W  signed operand
- b  in  COEF_W  signed coefficient
- out_valid  out  1  result valid, one ce-enabled cycle per frame
- p  out  OUT_W  signed saturated result
- out_len  out  $clog2(MAX_LEN+1)  number of terms in reported frame
- sat  out  1  result or accumulator saturated in reported frame
- err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset (sclr_n=0, async): all pipeline registers, accumulator, counter and outputs = 0; state = IDLE. Reset mid-frame discards the frame, and no out_valid is produced for it.
- ce=0: every register holds, including out_valid and err. Consumers qualify out_valid and err with ce.
- Stage 1 (ce=1): prod <= a*b, full signed, PROD_W = DATA_W+COEF_W. prod is 0 if a==0 or b==0. v1/first1/last1 <= in_valid/in_first/in_last.
- Stage 2 FSM, states IDLE and ACCUM, evaluated on v1:
  - IDLE, v1 & first1: acc <= sext(prod); cnt <= 1; frame_sat <= 0; goes to ACCUM, or finishes immediately if last1.
  - IDLE, v1 & !first1: term dropped; err pulses; stays IDLE.
  - ACCUM, v1 & !first1: acc <= sat_acc(acc + sext(prod)); cnt <= cnt+1.
  - ACCUM, v1 & first1: old frame discarded without output; err pulses; new frame starts as in IDLE.
  - ACCUM, !v1: hold.
- Frame finish on the term carrying last1, or when cnt reaches MAX_LEN without last (forced close, err pulses):
  - out_valid <= 1; p <= sat_out(acc_next >>> SHIFT).
  - out_len <= cnt_next; sat <= frame_sat | output saturation.
  - Return to IDLE.
- Result timing:
  - Latency: last term accepted on ce-cycle t gives out_valid on ce-cycle t+2.
  - out_valid clears on the next ce-cycle unless another frame finishes.
  - Back-to-back frames (first directly after last) are supported at full rate.
- sat_acc: the ACC_W sum saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sets frame_sat; there is no wrap.
- sat_out: clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. The shift truncates toward minus infinity, with no rounding.
- Simultaneous in_first & in_last on one beat makes a one-term frame with out_len=1.
- p and out_len hold their last values while out_valid=0.

Test Plan:
- Reset: drive sclr_n=0 with random inputs -> p=0, out_valid=0, sat=0, err=0, out_len=0. Release, one idle ce-cycle -> outputs unchanged.
- 3-term frame (defaults), (a,b) = (3,4), (-2,5), (127,127) on consecutive ce-cycles -> exactly 2 ce-cycles after last: out_valid=1, p=16131, out_len=3, sat=0.
- Single-term frame with first=last=1, a=-128, b=-128 -> p=16384, out_len=1. Repeat back-to-back with a=0, b=-7 -> next cycle p=0.
- Output saturation: 3 terms of 127*127 (sum 48387) -> p=32767, sat=1. Same with SHIFT=2 -> p=12096, sat=0.
- Protocol errors:
  - in_valid without first in IDLE -> err pulse, no output.
  - in_first mid-frame after 2 terms -> err pulse; only the new frame is reported, with the correct out_len.
  - MAX_LEN=4, 5 terms without last -> forced close with out_len=4, err pulse.
- Stalls and reset:
  - ce=0 for 3 cycles inside a frame and while out_valid=1 -> sum unchanged; out_valid held; exactly one ce-qualified result.
  - sclr_n asserted mid-frame -> immediate zeros and no result for the aborted frame.
